// File: rtl/midi_msg_parser.sv
`default_nettype none
// ============================================================================
// midi_msg_parser -- MIDI 1.0 channel-message parser behind a UART receiver.
// Revision 1.0
// ============================================================================
module midi_msg_parser #(
  parameter logic [23:0] TIMEOUT_CYC = 24'd2700000,
  parameter logic        VEL0_AS_OFF = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_res_n,
  input  logic       i_rxDone,
  input  logic [7:0] i_rxData,
  input  logic       i_omni,
  input  logic [3:0] i_chSel,
  output logic       o_msgValid,
  output logic [2:0] o_msgType,
  output logic [3:0] o_channel,
  output logic [6:0] o_data1,
  output logic [6:0] o_data2,
  output logic [7:0] o_errCnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_D1 = 3'd1,
    S_WAIT_D2 = 3'd2,
    S_SYSEX   = 3'd3,
    S_SYSCOM  = 3'd4
  } state_t;

  state_t      r_state,  w_state_nxt;
  logic [6:0]  r_status, w_status_nxt;
  logic [6:0]  r_data1,  w_data1_nxt;
  logic [1:0]  r_skip,   w_skip_nxt;
  logic [23:0] r_tmo,    w_tmo_nxt;

  logic       w_act;
  logic       w_err;
  logic       w_done;
  logic       w_emit;
  logic [6:0] w_msgD1;
  logic [6:0] w_msgD2;
  logic [2:0] w_msgType;

  // Realtime bytes are transparent: they never count as activity.
  assign w_act = i_rxDone && (i_rxData < 8'hF8);

  always_comb begin
    w_state_nxt  = r_state;
    w_status_nxt = r_status;
    w_data1_nxt  = r_data1;
    w_skip_nxt   = r_skip;
    w_tmo_nxt    = r_tmo;
    w_err        = 1'b0;
    w_done       = 1'b0;
    w_msgD1      = 7'd0;
    w_msgD2      = 7'd0;

    if (w_act) begin
      w_tmo_nxt = 24'd0;
      if (i_rxData[7]) begin
        if (i_rxData < 8'hF0) begin
          if (r_state == S_WAIT_D2) w_err = 1'b1;
          w_status_nxt = i_rxData[6:0];
          w_state_nxt  = S_WAIT_D1;
        end else begin
          w_status_nxt = 7'd0;
          w_state_nxt  = S_IDLE;
          case (i_rxData)
            8'hF0: w_state_nxt = S_SYSEX;
            8'hF1, 8'hF3: begin
              w_state_nxt = S_SYSCOM;
              w_skip_nxt  = 2'd1;
            end
            8'hF2: begin
              w_state_nxt = S_SYSCOM;
              w_skip_nxt  = 2'd2;
            end
            default: w_state_nxt = S_IDLE;
          endcase
        end
      end else begin
        case (r_state)
          S_IDLE: w_err = 1'b1;
          S_SYSEX: ;
          S_SYSCOM: begin
            if (r_skip <= 2'd1) w_state_nxt = S_IDLE;
            else                w_skip_nxt  = r_skip - 2'd1;
          end
          S_WAIT_D1: begin
            // Program Change / Channel Pressure carry a single data byte.
            if (r_status[6:5] == 2'b10) begin
              w_done  = 1'b1;
              w_msgD1 = i_rxData[6:0];
            end else begin
              w_data1_nxt = i_rxData[6:0];
              w_state_nxt = S_WAIT_D2;
            end
          end
          S_WAIT_D2: begin
            w_done      = 1'b1;
            w_msgD1     = r_data1;
            w_msgD2     = i_rxData[6:0];
            w_state_nxt = S_WAIT_D1;
          end
          default: w_state_nxt = S_IDLE;
        endcase
      end
    end else if ((r_state == S_WAIT_D2) && (TIMEOUT_CYC != 24'd0)) begin
      if (r_tmo >= TIMEOUT_CYC - 24'd1) begin
        w_err       = 1'b1;
        w_tmo_nxt   = 24'd0;
        w_state_nxt = S_WAIT_D1;
      end else begin
        w_tmo_nxt = r_tmo + 24'd1;
      end
    end
  end

  assign w_emit = w_done && (i_omni || (r_status[3:0] == i_chSel));

  always_comb begin
    w_msgType = r_status[6:4];
    if (VEL0_AS_OFF && (r_status[6:4] == 3'd1) && (w_msgD2 == 7'd0))
      w_msgType = 3'd0;
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      r_state    <= S_IDLE;
      r_status   <= 7'd0;
      r_data1    <= 7'd0;
      r_skip     <= 2'd0;
      r_tmo      <= 24'd0;
      o_msgValid <= 1'b0;
      o_msgType  <= 3'd0;
      o_channel  <= 4'd0;
      o_data1    <= 7'd0;
      o_data2    <= 7'd0;
      o_errCnt   <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_status   <= w_status_nxt;
      r_data1    <= w_data1_nxt;
      r_skip     <= w_skip_nxt;
      r_tmo      <= w_tmo_nxt;
      o_msgValid <= w_emit;
      if (w_emit) begin
        o_msgType <= w_msgType;
        o_channel <= r_status[3:0];
        o_data1   <= w_msgD1;
        o_data2   <= w_msgD2;
      end
      if (w_err && (o_errCnt != 8'hFF))
        o_errCnt <= o_errCnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_midi_msg_parser.sv
`default_nettype none
// Directed testbench for midi_msg_parser; each task checks its own scenario.
module tb_midi_msg_parser;

  localparam logic [23:0] TMO = 24'd40;

  logic       clk;
  logic       res_n;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       omni;
  logic [3:0] ch_sel;
  logic       msg_valid;
  logic [2:0] msg_type;
  logic [3:0] channel;
  logic [6:0] data1;
  logic [6:0] data2;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [20:0] q_msg[$];

  midi_msg_parser #(
    .TIMEOUT_CYC (TMO),
    .VEL0_AS_OFF (1'b1)
  ) u_dut (
    .i_clk      (clk),
    .i_res_n    (res_n),
    .i_rxDone   (rx_done),
    .i_rxData   (rx_data),
    .i_omni     (omni),
    .i_chSel    (ch_sel),
    .o_msgValid (msg_valid),
    .o_msgType  (msg_type),
    .o_channel  (channel),
    .o_data1    (data1),
    .o_data2    (data2),
    .o_errCnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (msg_valid === 1'b1) q_msg.push_back({msg_type, channel, data1, data2});

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [20:0] mk(input logic [2:0] t, input logic [3:0] c,
                                     input logic [6:0] a, input logic [6:0] b);
    return {t, c, a, b};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_done = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    res_n = 1'b0; rx_done = 1'b0; rx_data = 8'h00; omni = 1'b1; ch_sel = 4'd0;
    repeat (3) @(negedge clk);
    res_n = 1'b1;
    @(negedge clk);
    n_checks++; if (msg_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid got=%b exp=0", msg_valid); end
    n_checks++; if (msg_type !== 3'd0) begin n_errors++; $display("FAIL rst_type got=%0d exp=0", msg_type); end
    n_checks++; if (channel !== 4'd0) begin n_errors++; $display("FAIL rst_channel got=%0d exp=0", channel); end
    n_checks++; if (data1 !== 7'd0) begin n_errors++; $display("FAIL rst_data1 got=%h exp=0", data1); end
    n_checks++; if (data2 !== 7'd0) begin n_errors++; $display("FAIL rst_data2 got=%h exp=0", data2); end
    n_checks++; if (err_cnt !== 8'd0) begin n_errors++; $display("FAIL rst_errcnt got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_note_on();
    send_byte(8'h90);
    n_checks++; if (msg_valid !== 1'b0) begin n_errors++; $display("FAIL non_early got=%b exp=0", msg_valid); end
    send_byte(8'h3C);
    send_byte(8'h64);
    n_checks++; if (msg_valid !== 1'b1) begin n_errors++; $display("FAIL non_valid got=%b exp=1", msg_valid); end
    n_checks++;
    if ({msg_type, channel, data1, data2} !== mk(3'd1, 4'd0, 7'h3C, 7'h64)) begin
      n_errors++; $display("FAIL non_fields got=%h exp=%h", {msg_type, channel, data1, data2}, mk(3'd1, 4'd0, 7'h3C, 7'h64));
    end
    @(negedge clk);
    n_checks++; if (msg_valid !== 1'b0) begin n_errors++; $display("FAIL non_oneshot got=%b exp=0", msg_valid); end
    n_checks++; if (data2 !== 7'h64) begin n_errors++; $display("FAIL non_hold got=%h exp=64", data2); end
    n_checks++; if (err_cnt !== 8'd0) begin n_errors++; $display("FAIL non_errcnt got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_running_status();
    logic [7:0] seq [5] = '{8'h93, 8'h40, 8'h7F, 8'h40, 8'h00};
    settle(); q_msg.delete();
    foreach (seq[i]) send_byte(seq[i]);
    settle();
    n_checks++; if (q_msg.size() !== 2) begin n_errors++; $display("FAIL rs_count got=%0d exp=2", q_msg.size()); end
    n_checks++; if (q_msg[0] !== mk(3'd1, 4'd3, 7'h40, 7'h7F)) begin n_errors++; $display("FAIL rs_msg0 got=%h exp=%h", q_msg[0], mk(3'd1, 4'd3, 7'h40, 7'h7F)); end
    n_checks++; if (q_msg[1] !== mk(3'd0, 4'd3, 7'h40, 7'h00)) begin n_errors++; $display("FAIL rs_vel0 got=%h exp=%h", q_msg[1], mk(3'd0, 4'd3, 7'h40, 7'h00)); end
  endtask

  task automatic test_realtime();
    logic [7:0] seq [5] = '{8'hB1, 8'hF8, 8'h07, 8'hFE, 8'h64};
    q_msg.delete();
    foreach (seq[i]) send_byte(seq[i]);
    settle();
    n_checks++; if (q_msg.size() !== 1) begin n_errors++; $display("FAIL rt_count got=%0d exp=1", q_msg.size()); end
    n_checks++; if (q_msg[0] !== mk(3'd3, 4'd1, 7'h07, 7'h64)) begin n_errors++; $display("FAIL rt_msg got=%h exp=%h", q_msg[0], mk(3'd3, 4'd1, 7'h07, 7'h64)); end
    n_checks++; if (err_cnt !== 8'd0) begin n_errors++; $display("FAIL rt_errcnt got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_prog_change();
    logic [7:0] seq [3] = '{8'hC5, 8'h0A, 8'h0B};
    q_msg.delete();
    foreach (seq[i]) send_byte(seq[i]);
    settle();
    n_checks++; if (q_msg.size() !== 2) begin n_errors++; $display("FAIL pc_count got=%0d exp=2", q_msg.size()); end
    n_checks++; if (q_msg[0] !== mk(3'd4, 4'd5, 7'h0A, 7'h00)) begin n_errors++; $display("FAIL pc_msg0 got=%h exp=%h", q_msg[0], mk(3'd4, 4'd5, 7'h0A, 7'h00)); end
    n_checks++; if (q_msg[1] !== mk(3'd4, 4'd5, 7'h0B, 7'h00)) begin n_errors++; $display("FAIL pc_msg1 got=%h exp=%h", q_msg[1], mk(3'd4, 4'd5, 7'h0B, 7'h00)); end
  endtask

  task automatic test_sysex_timeout();
    logic [7:0] seq [5] = '{8'hF0, 8'h41, 8'h10, 8'hF7, 8'h55};
    q_msg.delete();
    foreach (seq[i]) send_byte(seq[i]);
    settle();
    n_checks++; if (q_msg.size() !== 0) begin n_errors++; $display("FAIL sx_count got=%0d exp=0", q_msg.size()); end
    n_checks++; if (err_cnt !== 8'd1) begin n_errors++; $display("FAIL sx_errcnt got=%0d exp=1", err_cnt); end
    send_byte(8'h90);
    send_byte(8'h3C);
    repeat (int'(TMO) - 5) @(negedge clk);
    n_checks++; if (err_cnt !== 8'd1) begin n_errors++; $display("FAIL to_early got=%0d exp=1", err_cnt); end
    repeat (10) @(negedge clk);
    n_checks++; if (err_cnt !== 8'd2) begin n_errors++; $display("FAIL to_fired got=%0d exp=2", err_cnt); end
    q_msg.delete();
    send_byte(8'h3C);
    send_byte(8'h10);
    settle();
    n_checks++; if (q_msg.size() !== 1) begin n_errors++; $display("FAIL to_count got=%0d exp=1", q_msg.size()); end
    n_checks++; if (q_msg[0] !== mk(3'd1, 4'd0, 7'h3C, 7'h10)) begin n_errors++; $display("FAIL to_msg got=%h exp=%h", q_msg[0], mk(3'd1, 4'd0, 7'h3C, 7'h10)); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [6] = '{8'h80, 8'h3C, 8'h40, 8'hA2, 8'h3C, 8'h50};
    q_msg.delete();
    foreach (seq[i]) begin
      @(negedge clk);
      rx_done = 1'b1;
      rx_data = seq[i];
    end
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'h00;
    settle();
    n_checks++; if (q_msg.size() !== 2) begin n_errors++; $display("FAIL b2b_count got=%0d exp=2", q_msg.size()); end
    n_checks++; if (q_msg[0] !== mk(3'd0, 4'd0, 7'h3C, 7'h40)) begin n_errors++; $display("FAIL b2b_msg0 got=%h exp=%h", q_msg[0], mk(3'd0, 4'd0, 7'h3C, 7'h40)); end
    n_checks++; if (q_msg[1] !== mk(3'd2, 4'd2, 7'h3C, 7'h50)) begin n_errors++; $display("FAIL b2b_msg1 got=%h exp=%h", q_msg[1], mk(3'd2, 4'd2, 7'h3C, 7'h50)); end
    n_checks++; if (err_cnt !== 8'd2) begin n_errors++; $display("FAIL b2b_errcnt got=%0d exp=2", err_cnt); end
  endtask

  task automatic test_filter_reset();
    logic [7:0] seq [6] = '{8'h91, 8'h3C, 8'h40, 8'h92, 8'h3C, 8'h40};
    omni = 1'b0; ch_sel = 4'd2;
    q_msg.delete();
    foreach (seq[i]) send_byte(seq[i]);
    settle();
    n_checks++; if (q_msg.size() !== 1) begin n_errors++; $display("FAIL flt_count got=%0d exp=1", q_msg.size()); end
    n_checks++; if (q_msg[0] !== mk(3'd1, 4'd2, 7'h3C, 7'h40)) begin n_errors++; $display("FAIL flt_msg got=%h exp=%h", q_msg[0], mk(3'd1, 4'd2, 7'h3C, 7'h40)); end
    q_msg.delete();
    send_byte(8'h92);
    #2 res_n = 1'b0;
    #1;
    n_checks++;
    if ({msg_valid, msg_type, channel, data1, data2, err_cnt} !== 30'd0) begin
      n_errors++; $display("FAIL rstmid_outputs got=%h exp=0", {msg_valid, msg_type, channel, data1, data2, err_cnt});
    end
    repeat (2) @(negedge clk);
    res_n = 1'b1;
    send_byte(8'h3C);
    send_byte(8'h40);
    settle();
    n_checks++; if (q_msg.size() !== 0) begin n_errors++; $display("FAIL rstmid_count got=%0d exp=0", q_msg.size()); end
    n_checks++; if ({msg_type, channel, data1, data2} !== 21'd0) begin n_errors++; $display("FAIL rstmid_fields got=%h exp=0", {msg_type, channel, data1, data2}); end
    n_checks++; if (err_cnt !== 8'd2) begin n_errors++; $display("FAIL rstmid_errcnt got=%0d exp=2", err_cnt); end
  endtask

  task automatic test_partial_syscom();
    logic [7:0] seq [5] = '{8'h90, 8'h3C, 8'h91, 8'h3C, 8'h40};
    logic [7:0] sc  [4] = '{8'hF2, 8'h10, 8'h20, 8'h30};
    omni = 1'b1;
    q_msg.delete();
    foreach (seq[i]) send_byte(seq[i]);
    settle();
    n_checks++; if (q_msg.size() !== 1) begin n_errors++; $display("FAIL part_count got=%0d exp=1", q_msg.size()); end
    n_checks++; if (q_msg[0] !== mk(3'd1, 4'd1, 7'h3C, 7'h40)) begin n_errors++; $display("FAIL part_msg got=%h exp=%h", q_msg[0], mk(3'd1, 4'd1, 7'h3C, 7'h40)); end
    n_checks++; if (err_cnt !== 8'd3) begin n_errors++; $display("FAIL part_errcnt got=%0d exp=3", err_cnt); end
    q_msg.delete();
    for (int i = 0; i < 3; i++) send_byte(sc[i]);
    n_checks++; if (err_cnt !== 8'd3) begin n_errors++; $display("FAIL sc_skip got=%0d exp=3", err_cnt); end
    send_byte(sc[3]);
    settle();
    n_checks++; if (err_cnt !== 8'd4) begin n_errors++; $display("FAIL sc_stray got=%0d exp=4", err_cnt); end
    n_checks++; if (q_msg.size() !== 0) begin n_errors++; $display("FAIL sc_count got=%0d exp=0", q_msg.size()); end
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_running_status();
    test_realtime();
    test_prog_change();
    test_sysex_timeout();
    test_back_to_back();
    test_filter_reset();
    test_partial_syscom();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
